fetch_unit: RTL

Instruction fetch stage directly upstream of the controller. Keeps the program counter and issues word reads to instruction memory over a valid/ready request channel, accepting in-order responses. Buffers up to two fetched instructions and presents them to decode with the opcode, funct3 and funct7 fields pre-sliced for the controller. Accepts a branch/jump redirect from execute, which flushes all in-flight and buffered instructions.

---
 rtl/fetch_unit.sv | 84 ++++++++
 1 files changed

// File: rtl/fetch_unit.sv
// fetch_unit: PC, instruction-memory requests, 2-entry decode buffer, redirect flush
module fetch_unit #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        reset,
   output logic        imem_req_valid,
   input  logic        imem_req_ready,
   output logic [31:0] imem_addr,
   input  logic        imem_rsp_valid,
   input  logic [31:0] imem_rsp_data,
   input  logic        redirect_valid,
   input  logic [31:0] redirect_pc,
   output logic        dec_valid,
   input  logic        dec_ready,
   output logic [31:0] dec_instr,
   output logic [31:0] dec_pc,
   output logic [6:0]  dec_op,
   output logic [2:0]  dec_funct3,
   output logic [6:0]  dec_funct7,
   output logic        dec_illegal
);
   logic [31:0] pc;
   logic [31:0] f_instr [2];
   logic [31:0] f_pc [2];
   logic [31:0] q_pc [2];
   logic        f_rd, f_wr, q_rd, q_wr;
   logic [1:0]  cnt, outs, drop;
   logic        req_acc, fifo_wr, fifo_rd;
   // credit check, handshakes and pre-sliced decode fields of the buffer head
   always_comb begin
      imem_req_valid = !reset && !redirect_valid && ({1'b0, outs} + {1'b0, cnt} < 3'd2);
      imem_addr      = pc;
      req_acc        = imem_req_valid && imem_req_ready;
      dec_valid      = !reset && !redirect_valid && (cnt != 2'd0);
      fifo_rd        = dec_valid && dec_ready;
      fifo_wr        = !reset && !redirect_valid && imem_rsp_valid && (drop == 2'd0);
      dec_instr      = f_instr[f_rd];
      dec_pc         = f_pc[f_rd];
      dec_op         = dec_instr[6:0];
      dec_funct3     = dec_instr[14:12];
      dec_funct7     = dec_instr[31:25];
      dec_illegal    = dec_instr[1:0] != 2'b11;
   end
   // pc, decode buffer, outstanding/drop accounting and response-PC queue
   always_ff @(posedge clk) begin
      if (reset) begin
         pc      <= RESET_PC;
         f_instr <= '{default: '0};
         f_pc    <= '{default: '0};
         q_pc    <= '{default: '0};
         f_rd    <= 1'b0;
         f_wr    <= 1'b0;
         q_rd    <= 1'b0;
         q_wr    <= 1'b0;
         cnt     <= 2'd0;
         outs    <= 2'd0;
         drop    <= 2'd0;
      end else begin
         if (redirect_valid) begin
            pc   <= redirect_pc & ~32'h3;
            cnt  <= 2'd0;
            f_wr <= f_rd;
            drop <= outs - 2'(imem_rsp_valid);
         end else begin
            if (req_acc) pc <= pc + 32'd4;
            if (fifo_wr) begin
               f_instr[f_wr] <= imem_rsp_data;
               f_pc[f_wr]    <= q_pc[q_rd];
               f_wr          <= ~f_wr;
            end
            if (fifo_rd) f_rd <= ~f_rd;
            cnt <= cnt + 2'(fifo_wr) - 2'(fifo_rd);
            if (imem_rsp_valid && drop != 2'd0) drop <= drop - 2'd1;
         end
         if (req_acc) begin
            q_pc[q_wr] <= pc;
            q_wr       <= ~q_wr;
         end
         if (imem_rsp_valid) q_rd <= ~q_rd;
         outs <= outs + 2'(req_acc) - 2'(imem_rsp_valid);
      end
   end
endmodule
